// File: rtl/npc_pkg.sv
// Shared types and level-scaling helpers for the NPC wave manager.
// The optional multi-hit HP feature is selected with NPC_MULTI_HIT_EN.
package npc_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SPAWN  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_CLEAR  = 2'd3
    } npc_state_e;

    localparam int NUM_NPC_DEF = 10;
    localparam int MAX_LEVEL   = 4;
    localparam int HP_W        = 3;

    // Levels above MAX_LEVEL behave exactly like MAX_LEVEL.
    function automatic int clamp_level(input logic [2:0] lvl);
        return (int'(lvl) > MAX_LEVEL) ? MAX_LEVEL : int'(lvl);
    endfunction

    function automatic logic [HP_W-1:0] level_hp(input logic [2:0] lvl);
        return HP_W'(clamp_level(lvl) + 1);
    endfunction

    function automatic int level_gap(input logic [2:0] lvl, input int spawn_gap);
        int gap;
        gap = spawn_gap >> clamp_level(lvl);
        return (gap < 1) ? 1 : gap;
    endfunction

endpackage

// File: rtl/npc_wave_manager_if.sv
// Projectile hit report channel between collision logic and the wave manager.
interface npc_wave_manager_if #(
    parameter int IDX_W = 4
) ();
    logic             hit_valid;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_ready;

    modport master (output hit_valid, output hit_idx, input hit_ready);
    modport slave  (input hit_valid, input hit_idx, output hit_ready);
endinterface

// File: rtl/npc_spawn_timer.sv
// Frame-tick gap counter; pulses spawn_now on the tick that finds it at 1.
module npc_spawn_timer #(
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] gap_reload,
    output logic             spawn_now
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload_q;

    // The reload value is captured at load so later Curr_Level changes cannot skew the stagger.
    always_ff @(posedge Clk) begin
        if (Reset || load) begin
            cnt      <= gap_reload;
            reload_q <= gap_reload;
        end else if (enable && frame_tick) begin
            cnt <= (cnt == CNT_W'(1)) ? reload_q : cnt - CNT_W'(1);
        end
    end

    assign spawn_now = enable && frame_tick && (cnt == CNT_W'(1));

endmodule

// File: rtl/npc_wave_manager.sv
// Enemy wave loader/spawner with hit handling and the level controller's alive vector.
// Define NPC_MULTI_HIT_EN for per-NPC hit points; otherwise one accepted hit kills.
module npc_wave_manager
    import npc_pkg::*;
#(
    parameter int NUM_NPC   = NUM_NPC_DEF,
    parameter int SPAWN_GAP = 16,
    parameter int IDX_W     = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic [2:0]         Curr_Level,
    input  logic               Change,
    input  logic               NewGame,
    npc_wave_manager_if.slave  hit,
    output logic [NUM_NPC-1:0] NPC_alive,
    output logic [NUM_NPC-1:0] NPC_visible,
    output logic               wave_active,
    output logic               score_inc
);

    localparam int CNT_W = $clog2(SPAWN_GAP) + 1;

    npc_state_e         state;
    logic [NUM_NPC-1:0] pending;
    logic [NUM_NPC-1:0] hit_mask;
    logic [NUM_NPC-1:0] kill_mask;
    logic [NUM_NPC-1:0] spawn_mask;
    logic [NUM_NPC-1:0] pending_nxt;
    logic [NUM_NPC-1:0] visible_nxt;
    logic               hit_ready_q;
    logic               load;
    logic               spawn_now;
    logic [CNT_W-1:0]   gap_reload;

    assign load          = Reset || NewGame || Change;
    assign gap_reload    = CNT_W'(level_gap(Curr_Level, SPAWN_GAP));
    assign hit.hit_ready = hit_ready_q;

    npc_spawn_timer #(.CNT_W(CNT_W)) u_spawn_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .load       (load),
        .enable     (state == ST_SPAWN),
        .gap_reload (gap_reload),
        .spawn_now  (spawn_now)
    );

    // Hits are qualified by the registered visible bits, so an NPC spawning this cycle is immune.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        hit_mask = '0;
        for (int i = 0; i < NUM_NPC; i++) begin
            hit_mask[i] = hit.hit_valid && hit_ready_q &&
                          (hit.hit_idx == IDX_W'(i)) && NPC_visible[i];
        end
    end

`ifdef NPC_MULTI_HIT_EN
    logic [HP_W-1:0] hp [NUM_NPC];

    // NOTE: the HP array has no reset branch of its own; the load path (which includes Reset) initialises it.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_NPC; i++) begin
            if (load) begin
                hp[i] <= level_hp(Curr_Level);
            end else if (hit_mask[i] && (hp[i] != '0)) begin
                hp[i] <= hp[i] - HP_W'(1);
            end
        end
    end

    always_comb begin
        kill_mask = '0;
        for (int i = 0; i < NUM_NPC; i++) begin
            kill_mask[i] = hit_mask[i] && (hp[i] <= HP_W'(1));
        end
    end
`else
    assign kill_mask = hit_mask;
`endif

    // Spawns always take the lowest-index pending NPC.
    assign spawn_mask  = spawn_now ? (pending & (~pending + NUM_NPC'(1))) : '0;
    assign pending_nxt = pending & ~spawn_mask;
    assign visible_nxt = (NPC_visible & ~kill_mask) | spawn_mask;

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments; the early default makes score_inc a one-cycle pulse.
        score_inc <= 1'b0;
        if (load) begin
            state       <= ST_LOAD;
            pending     <= '1;
            NPC_visible <= '0;
            NPC_alive   <= '1;
            wave_active <= 1'b0;
            hit_ready_q <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    state       <= ST_SPAWN;
                    wave_active <= 1'b1;
                    hit_ready_q <= 1'b1;
                end
                ST_SPAWN, ST_ACTIVE: begin
                    pending     <= pending_nxt;
                    NPC_visible <= visible_nxt;
                    NPC_alive   <= pending_nxt | visible_nxt;
                    score_inc   <= |kill_mask;
                    if (state == ST_SPAWN && pending_nxt == '0) begin
                        state <= ST_ACTIVE;
                    end else if (state == ST_ACTIVE && visible_nxt == '0) begin
                        state       <= ST_CLEAR;
                        wave_active <= 1'b0;
                        hit_ready_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    NPC_alive <= '0;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_wave_manager.sv
// Randomised + directed bench for npc_wave_manager against a wave-level reference model.
module tb_npc_wave_manager;

    localparam int N   = 10;
    localparam int GAP = 16;
    localparam int IW  = 4;
    localparam int P_LOAD = 0, P_SPAWN = 1, P_ACTIVE = 2, P_CLEAR = 3;
`ifdef NPC_MULTI_HIT_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset, frame_tick, Change, NewGame;
    logic [2:0]   Curr_Level;
    logic [N-1:0] NPC_alive, NPC_visible;
    logic         wave_active, score_inc;

    npc_wave_manager_if #(.IDX_W(IW)) hit_bus ();

    npc_wave_manager #(.NUM_NPC(N), .SPAWN_GAP(GAP), .IDX_W(IW)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .Curr_Level  (Curr_Level),
        .Change      (Change),
        .NewGame     (NewGame),
        .hit         (hit_bus.slave),
        .NPC_alive   (NPC_alive),
        .NPC_visible (NPC_visible),
        .wave_active (wave_active),
        .score_inc   (score_inc)
    );

    always #5 Clk = ~Clk;

    // Reference model: NPCs 0..m_spawned-1 have appeared; an NPC is dead once its HP hits 0.
    int m_phase, m_gap, m_spawned, m_ticks;
    int m_hp [N];
    bit m_score;
    int checks = 0;
    int errors = 0;

    function automatic bit m_vis(input int i);
        return (i < m_spawned) && (m_hp[i] > 0);
    endfunction

    function automatic logic [N-1:0] exp_visible();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_vis(i);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_alive();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (i >= m_spawned) || m_vis(i);
        return v;
    endfunction

    function automatic logic exp_active();
        return (m_phase == P_SPAWN) || (m_phase == P_ACTIVE);
    endfunction

    task automatic model_clock();
        int lvl;
        int idx;
        m_score = 1'b0;
        if (Reset || NewGame || Change) begin
            lvl       = (Curr_Level > 3'd4) ? 4 : int'(Curr_Level);
            m_phase   = P_LOAD;
            m_gap     = GAP >> lvl;
            if (m_gap < 1) m_gap = 1;
            m_spawned = 0;
            m_ticks   = 0;
            for (int i = 0; i < N; i++) m_hp[i] = MULTI ? lvl + 1 : 1;
        end else if (m_phase == P_LOAD) begin
            m_phase = P_SPAWN;
        end else if (m_phase == P_SPAWN || m_phase == P_ACTIVE) begin
            idx = int'(hit_bus.hit_idx);
            if (hit_bus.hit_valid && idx < N && m_vis(idx)) begin
                m_hp[idx]--;
                if (m_hp[idx] == 0) m_score = 1'b1;
            end
            if (m_phase == P_SPAWN && frame_tick) begin
                m_ticks++;
                if (m_ticks == (m_spawned + 1) * m_gap) m_spawned++;
                if (m_spawned == N) m_phase = P_ACTIVE;
            end else if (m_phase == P_ACTIVE && exp_visible() == '0) begin
                m_phase = P_CLEAR;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, DUT compared on the following falling edge.
    task automatic step();
        @(posedge Clk);
        model_clock();
        @(negedge Clk);
        check("alive",       NPC_alive,         exp_alive());
        check("visible",     NPC_visible,       exp_visible());
        check("wave_active", wave_active,       exp_active());
        check("hit_ready",   hit_bus.hit_ready, exp_active());
        check("score_inc",   score_inc,         m_score);
        Reset             = 1'b0;
        Change            = 1'b0;
        frame_tick        = 1'b0;
        hit_bus.hit_valid = 1'b0;
    endtask

    function automatic logic [IW-1:0] pick_target();
        int cand[$];
        for (int i = 0; i < N; i++) if (m_vis(i)) cand.push_back(i);
        if (cand.size() == 0 || $urandom_range(0, 7) == 0) return IW'($urandom_range(0, 15));
        return IW'(cand[$urandom_range(0, cand.size() - 1)]);
    endfunction

    int hp0;
    int score_seen;

    initial begin
        Reset = 1'b1; NewGame = 1'b1; Change = 1'b0; frame_tick = 1'b0; Curr_Level = 3'd0;
        hit_bus.hit_valid = 1'b0; hit_bus.hit_idx = '0;
        m_phase = P_LOAD; m_spawned = 0; m_gap = GAP; m_ticks = 0; m_score = 1'b0;
        for (int i = 0; i < N; i++) m_hp[i] = 1;

        // Reset for two cycles, then held in LOAD by NewGame
        step(); Reset = 1'b1; step();
        for (int c = 0; c < 3; c++) step();
        check("load_alive", NPC_alive, 10'h3FF);

        // Level 0: full spawn with a tick every other cycle
        NewGame = 1'b0;
        for (int c = 0; c < 1000 && m_spawned < N; c++) begin
            frame_tick = c[0];
            step();
        end
        check("l0_all_visible", NPC_visible, 10'h3FF);
        check("l0_active", wave_active, 1'b1);

        // Level 2: repeated hits on NPC 3
        Curr_Level = 3'd2; Change = 1'b1; step(); step();
        for (int c = 0; c < 200 && !m_vis(3); c++) begin
            frame_tick = 1'b1;
            step();
        end
        check("l2_spawned3", NPC_visible[3], 1'b1);
        hp0 = MULTI ? 3 : 1;
        score_seen = 0;
        for (int k = 1; k <= 3; k++) begin
            hit_bus.hit_valid = 1'b1; hit_bus.hit_idx = 4'd3;
            step();
            check("l2_vis3", NPC_visible[3], (k < hp0));
            score_seen += int'(score_inc);
        end
        check("l2_score_count", score_seen, 1);

        // Out-of-range index, then an NPC that has not spawned yet
        hit_bus.hit_valid = 1'b1; hit_bus.hit_idx = 4'd12; step();
        check("bad_idx_score", score_inc, 1'b0);
        hit_bus.hit_valid = 1'b1; hit_bus.hit_idx = 4'd9; step();
        check("unspawned_score", score_inc, 1'b0);
        check("unspawned_alive9", NPC_alive[9], 1'b1);

        // Kill the whole wave, then move to level 3
        for (int c = 0; c < 3000 && m_phase != P_CLEAR; c++) begin
            frame_tick = 1'b1;
            hit_bus.hit_valid = 1'b1; hit_bus.hit_idx = pick_target();
            step();
        end
        check("clear_alive", NPC_alive, 10'h000);
        check("clear_wave_active", wave_active, 1'b0);
        step();
        Curr_Level = 3'd3; Change = 1'b1; step();
        check("l3_alive", NPC_alive, 10'h3FF);
        step();
        frame_tick = 1'b1; step();
        check("l3_gap_tick1", NPC_visible[0], 1'b0);
        frame_tick = 1'b1; step();
        check("l3_gap_tick2", NPC_visible[0], 1'b1);

        // Level 4: spawn and hit on NPC 0 in the same cycle, then kill it while still spawning
        Curr_Level = 3'd4; Change = 1'b1; step(); step();
        frame_tick = 1'b1; hit_bus.hit_valid = 1'b1; hit_bus.hit_idx = 4'd0; step();
        check("coll_vis0", NPC_visible[0], 1'b1);
        check("coll_score", score_inc, 1'b0);
        hp0 = MULTI ? 5 : 1;
        for (int k = 1; k <= hp0; k++) begin
            hit_bus.hit_valid = 1'b1; hit_bus.hit_idx = 4'd0; step();
            check("coll_hp_vis0", NPC_visible[0], (k < hp0));
        end
        check("lastkill_spawn_alive", NPC_alive, 10'h3FE);
        check("lastkill_spawn_active", wave_active, 1'b1);

        // Hit on a live NPC in the same cycle as Change
        frame_tick = 1'b1; step();
        hit_bus.hit_valid = 1'b1; hit_bus.hit_idx = 4'd1; Change = 1'b1; Curr_Level = 3'd1; step();
        check("hitchg_score", score_inc, 1'b0);
        check("hitchg_alive", NPC_alive, 10'h3FF);
        check("hitchg_active", wave_active, 1'b0);

        // Random episodes with occasional NewGame, Change and Reset mid-wave
        for (int ep = 0; ep < 30; ep++) begin
            int tick_den;
            Curr_Level = 3'($urandom_range(0, 7)); Change = 1'b1; step();
            tick_den = $urandom_range(1, 3);
            for (int c = 0; c < 700; c++) begin
                frame_tick        = ($urandom_range(1, tick_den) == 1);
                hit_bus.hit_valid = $urandom_range(0, 1);
                hit_bus.hit_idx   = pick_target();
                NewGame           = ($urandom_range(0, 299) == 0);
                Change            = ($urandom_range(0, 499) == 0);
                Reset             = ($urandom_range(0, 799) == 0);
                if (Change || Reset) Curr_Level = 3'($urandom_range(0, 7));
                step();
                if (m_phase == P_CLEAR && $urandom_range(0, 9) == 0) break;
            end
            NewGame = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
